key_entry: RTL
==============

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL have parameter N, default 8, operand/result width in bits.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_valid  in  1  key code present.
REQ-005 SHALL have port key_code  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear.
REQ-006 SHALL have port key_ready  out  1  key accepted when key_valid&key_ready.
REQ-007 SHALL have port alu_done  in  1  one-cycle pulse, downstream result valid.
REQ-008 SHALL have port result  in  N  downstream result, sampled on alu_done.
REQ-009 SHALL have port operand  out  N  value for the downstream operand register pair.
REQ-010 SHALL have port ld0  out  1  one-cycle load strobe, first operand.
REQ-011 SHALL have port ld1  out  1  one-cycle load strobe, second operand.
REQ-012 SHALL have port op  out  2  latched operation: 0 add, 1 sub, 2 mul, 3 div.
REQ-013 SHALL have port go  out  1  one-cycle start pulse to the ALU.
REQ-014 SHALL have port busy  out  1  high while awaiting alu_done.

Function
REQ-015 SHALL implement states ENTRY_A, ENTRY_B, EXEC, SHOW; all outputs registered.
REQ-016 key_ready SHALL be 1 in every state except EXEC; busy SHALL equal (state==EXEC).
REQ-017 Digit d accepted in ENTRY_A/ENTRY_B: acc = acc*10+d, computed at N+4 bits.
REQ-018 Operator accepted at cycle t in ENTRY_A: operand=acc, ld0=1 at t+1, op latched, acc=0, next state ENTRY_B.
REQ-019 Operator in ENTRY_B before any digit: op replaced, no strobe; after a digit: key ignored.
REQ-020 Equals accepted at t in ENTRY_B: operand=acc, ld1=1 at t+1, go=1 at t+2, state EXEC from t+1.
REQ-021 Equals in ENTRY_A or SHOW: ignored, no strobe.
REQ-022 EXEC: on alu_done, capture result into acc, next state SHOW; alu_done outside EXEC ignored.
REQ-023 SHOW: digit d sets acc=d, state ENTRY_A; operator chains: operand=acc (result), ld0 pulse, op latched, acc=0, state ENTRY_B.
REQ-024 Clear accepted in ENTRY_A/ENTRY_B/SHOW: acc=0, op=0, state ENTRY_A, no strobe.
REQ-025 ld0, ld1, go SHALL be mutually exclusive and never high two consecutive cycles.
REQ-026 operand SHALL hold its last driven value when no strobe is active.

Reset
REQ-027 rst SHALL force state ENTRY_A, acc=0, operand=0, op=0, ld0=ld1=go=0, busy=0, key_ready=1 at the next edge, overriding all inputs including mid-EXEC.

Configuration
REQ-028 Macro KEY_ENTRY_SAT_EN defined: digit making acc*10+d exceed 2^N-1 SHALL set acc=2^N-1.
REQ-029 KEY_ENTRY_SAT_EN undefined: such a digit SHALL be discarded, acc unchanged.

Structure
REQ-030 Package calc_pkg SHALL hold key code constants, op encoding, FSM state type.
REQ-031 Sub-module dec_acc SHALL implement the digit accumulate, overflow detect, saturate/discard logic.

Verification (N=8, macro undefined unless stated)
REQ-032 Keys 1,2,+,3,= -> ld0 with operand=12 op=0; ld1 with operand=3; go one cycle after ld1; busy until alu_done.
REQ-033 Keys 2,5,6 -> acc=25 (macro undefined); acc=255 (KEY_ENTRY_SAT_EN defined).
REQ-034 alu_done with result=40 in EXEC, then key * -> ld0 operand=40 op=2, state ENTRY_B.
REQ-035 Keys 7,+,4,C -> state ENTRY_A, acc=0; subsequent = produces no strobe.
REQ-036 key_valid held during EXEC -> key_ready=0, no state change; rst in EXEC -> ENTRY_A, all outputs at reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, op encoding and FSM state type for the calculator key entry.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ENTRY_A = 2'd0;
    localparam state_t ENTRY_B = 2'd1;
    localparam state_t EXEC    = 2'd2;
    localparam state_t SHOW    = 2'd3;

    typedef enum logic [1:0] {
        K_DIG,
        K_OP,
        K_EQ,
        K_CLR
    } key_cls_t;

    function automatic key_cls_t key_cls(input logic [3:0] k);
        key_cls_t c;
        if (k < KEY_ADD)       c = K_DIG;
        else if (k == KEY_EQ)  c = K_EQ;
        else if (k == KEY_CLR) c = K_CLR;
        else                   c = K_OP;
        return c;
    endfunction

    function automatic logic [1:0] key_op(input logic [3:0] k);
        logic [1:0] o;
        case (k)
            KEY_SUB: o = OP_SUB;
            KEY_MUL: o = OP_MUL;
            KEY_DIV: o = OP_DIV;
            default: o = OP_ADD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keypad and ALU-side handshake bundle of the key entry controller.
interface key_entry_if #(parameter int N = 8);

    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_ready;
    logic         alu_done;
    logic [N-1:0] result;
    logic [N-1:0] operand;
    logic         ld0;
    logic         ld1;
    logic [1:0]   op;
    logic         go;
    logic         busy;

    modport master (
        output key_valid, key_code, alu_done, result,
        input  key_ready, operand, ld0, ld1, op, go, busy
    );

    modport slave (
        input  key_valid, key_code, alu_done, result,
        output key_ready, operand, ld0, ld1, op, go, busy
    );

endinterface

// File: rtl/key_entry_dec_acc.sv
// Decimal digit accumulate with overflow detect.
// KEY_ENTRY_SAT_EN: saturate on overflow; otherwise the digit is discarded.
module dec_acc #(
    parameter int N = 8
) (
    input  logic [N-1:0] acc,
    input  logic [3:0]   digit,
    output logic [N-1:0] next_acc,
    output logic         ovf
);

    localparam int W = N + 4;

    logic [W-1:0] wide;

    // acc*10+9 < 16*2^N, so N+4 bits never wrap
    always_comb begin
        wide = {4'b0, acc} * W'(10) + W'(digit);
        ovf  = |wide[W-1:N];
`ifdef KEY_ENTRY_SAT_EN
        next_acc = ovf ? '1 : wide[N-1:0];
`else
        next_acc = ovf ? acc : wide[N-1:0];
`endif
    end

endmodule

// File: rtl/key_entry.sv
// Calculator key entry FSM: builds operands from digits and sequences the ALU.
// Build option KEY_ENTRY_SAT_EN selects saturating digit entry.
module key_entry
    import calc_pkg::*;
#(
    parameter int N = 8
) (
    input logic       clk,
    input logic       rst,
    key_entry_if.slave bus
);

    state_t       state, state_n;
    logic [N-1:0] acc, acc_n;
    logic [N-1:0] operand_q, operand_n;
    logic [1:0]   op_q, op_n;
    logic         has_dig, has_dig_n;
    logic         ld0_q, ld0_n;
    logic         ld1_q, ld1_n;
    logic         go_q;
    logic         ready_q;
    logic         busy_q;

    logic         accept;
    key_cls_t     cls;
    logic [N-1:0] acc_dig;
    logic         ovf;

    dec_acc #(.N(N)) u_dec_acc (
        .acc      (acc),
        .digit    (bus.key_code),
        .next_acc (acc_dig),
        .ovf      (ovf)
    );

    assign accept = bus.key_valid && ready_q;
    assign cls    = key_cls(bus.key_code);

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        operand_n = operand_q;
        op_n      = op_q;
        has_dig_n = has_dig;
        ld0_n     = 1'b0;
        ld1_n     = 1'b0;
        unique case (state)
            ENTRY_A: begin
                if (accept) begin
                    unique case (1'b1)
                        (cls == K_DIG): acc_n = acc_dig;
                        (cls == K_OP): begin
                            operand_n = acc;
                            ld0_n     = 1'b1;
                            op_n      = key_op(bus.key_code);
                            acc_n     = '0;
                            has_dig_n = 1'b0;
                            state_n   = ENTRY_B;
                        end
                        (cls == K_EQ): ;
                        (cls == K_CLR): begin
                            acc_n = '0;
                            op_n  = OP_ADD;
                        end
                    endcase
                end
            end
            ENTRY_B: begin
                if (accept) begin
                    unique case (1'b1)
                        (cls == K_DIG): begin
                            acc_n     = acc_dig;
                            has_dig_n = 1'b1;
                        end
                        (cls == K_OP): begin
                            if (!has_dig) op_n = key_op(bus.key_code);
                        end
                        (cls == K_EQ): begin
                            operand_n = acc;
                            ld1_n     = 1'b1;
                            state_n   = EXEC;
                        end
                        (cls == K_CLR): begin
                            acc_n   = '0;
                            op_n    = OP_ADD;
                            state_n = ENTRY_A;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (bus.alu_done) begin
                    acc_n   = bus.result;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (accept) begin
                    unique case (1'b1)
                        (cls == K_DIG): begin
                            acc_n   = N'(bus.key_code);
                            state_n = ENTRY_A;
                        end
                        (cls == K_OP): begin
                            operand_n = acc;
                            ld0_n     = 1'b1;
                            op_n      = key_op(bus.key_code);
                            acc_n     = '0;
                            has_dig_n = 1'b0;
                            state_n   = ENTRY_B;
                        end
                        (cls == K_EQ): ;
                        (cls == K_CLR): begin
                            acc_n   = '0;
                            op_n    = OP_ADD;
                            state_n = ENTRY_A;
                        end
                    endcase
                end
            end
        endcase
    end

    // ready/busy are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTRY_A;
            acc       <= '0;
            operand_q <= '0;
            op_q      <= OP_ADD;
            has_dig   <= 1'b0;
            ld0_q     <= 1'b0;
            ld1_q     <= 1'b0;
            go_q      <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            operand_q <= operand_n;
            op_q      <= op_n;
            has_dig   <= has_dig_n;
            ld0_q     <= ld0_n;
            ld1_q     <= ld1_n;
            go_q      <= ld1_q;
            ready_q   <= (state_n != EXEC);
            busy_q    <= (state_n == EXEC);
        end
    end

    assign bus.key_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.operand   = operand_q;
    assign bus.op        = op_q;
    assign bus.ld0       = ld0_q;
    assign bus.ld1       = ld1_q;
    assign bus.go        = go_q;

endmodule
